// File: rtl/reg_file_wb_pkg.sv
// Shared widths, index/data types and writeback-stage record for the register file.
package reg_file_wb_pkg;

  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t addr;
    word_t    data;
  } wb_entry_t;

  typedef struct packed {
    logic valid;
    logic data;
  } wbf_entry_t;

endpackage

// File: rtl/wb_bypass_mux.sv
// Bypass select: a valid pending stage entry whose address matches wins over architectural state.
// Latency: combinational. Backpressure: none.
module wb_bypass_mux #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          stage_vld,
  input  logic [AW-1:0] stage_addr,
  input  logic [AW-1:0] rd_addr,
  input  logic [W-1:0]  stage_dat,
  input  logic [W-1:0]  arch_dat,
  output logic [W-1:0]  rd_dat
);

  logic hit;

  always_comb begin
    hit    = stage_vld && (stage_addr == rd_addr);
    rd_dat = hit ? stage_dat : arch_dat;
  end

endmodule

// File: rtl/reg_file_wb.sv
// 16x8 register file plus flag, with a one-entry writeback stage that commits one edge after capture.
// Latency: reads combinational with bypass of the pending entry. Backpressure: none, one write per cycle.
module reg_file_wb
  import reg_file_wb_pkg::*;
(
  input  logic     CLK,
  input  logic     RESET_N,
  input  logic     WR_EN,
  input  reg_idx_t WR_ADDR,
  input  word_t    WR_DATA,
  input  logic     FLAG_WE,
  input  logic     FLAG_IN,
  input  reg_idx_t RD_A_ADDR,
  input  reg_idx_t RD_C_ADDR,
  output word_t    RD_A_DATA,
  output word_t    RD_C_DATA,
  output logic     FLAG_OUT,
  output logic     WB_BUSY
);

  word_t      regs [NUM_REGS];
  logic       flag_q;
  wb_entry_t  wb_q;
  wbf_entry_t wbf_q;

  // Commit of the old entry and capture of the new one share the same edge,
  // so back-to-back writes to one address leave the newer value in the stage.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      flag_q <= 1'b0;
      wb_q   <= '0;
      wbf_q  <= '0;
    end else begin
      if (wb_q.valid) begin
        regs[wb_q.addr] <= wb_q.data;
      end
      if (wbf_q.valid) begin
        flag_q <= wbf_q.data;
      end
      wb_q.valid <= WR_EN;
      if (WR_EN) begin
        wb_q.addr <= WR_ADDR;
        wb_q.data <= WR_DATA;
      end
      wbf_q.valid <= FLAG_WE;
      if (FLAG_WE) begin
        wbf_q.data <= FLAG_IN;
      end
    end
  end

  wb_bypass_mux #(.W(DATA_W), .AW(ADDR_W)) u_mux_a (
    .stage_vld  (wb_q.valid),
    .stage_addr (wb_q.addr),
    .rd_addr    (RD_A_ADDR),
    .stage_dat  (wb_q.data),
    .arch_dat   (regs[RD_A_ADDR]),
    .rd_dat     (RD_A_DATA)
  );

  wb_bypass_mux #(.W(DATA_W), .AW(ADDR_W)) u_mux_c (
    .stage_vld  (wb_q.valid),
    .stage_addr (wb_q.addr),
    .rd_addr    (RD_C_ADDR),
    .stage_dat  (wb_q.data),
    .arch_dat   (regs[RD_C_ADDR]),
    .rd_dat     (RD_C_DATA)
  );

  // The flag has no address, so both compare inputs are tied equal.
  wb_bypass_mux #(.W(1), .AW(1)) u_mux_flag (
    .stage_vld  (wbf_q.valid),
    .stage_addr (1'b0),
    .rd_addr    (1'b0),
    .stage_dat  (wbf_q.data),
    .arch_dat   (flag_q),
    .rd_dat     (FLAG_OUT)
  );

  assign WB_BUSY = wb_q.valid || wbf_q.valid;

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: directed vector table, hand sequences, random vs reference model.
module tb_reg_file_wb;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       WR_EN, FLAG_WE, FLAG_IN;
  logic [3:0] WR_ADDR, RD_A_ADDR, RD_C_ADDR;
  logic [7:0] WR_DATA, RD_A_DATA, RD_C_DATA;
  logic       FLAG_OUT, WB_BUSY;

  int checks = 0;
  int failures = 0;

  // Reference model: a write is architecturally visible from its capture edge on,
  // because the stage bypass always presents the newest captured value.
  int vis [16];
  int vflag;
  int vbusy;

  always #5 CLK = ~CLK;

  reg_file_wb dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .FLAG_WE(FLAG_WE), .FLAG_IN(FLAG_IN),
    .RD_A_ADDR(RD_A_ADDR), .RD_C_ADDR(RD_C_ADDR),
    .RD_A_DATA(RD_A_DATA), .RD_C_DATA(RD_C_DATA),
    .FLAG_OUT(FLAG_OUT), .WB_BUSY(WB_BUSY)
  );

  typedef struct {
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       fwe;
    logic       fin;
    logic [3:0] ra;
    logic [3:0] rc;
    logic [7:0] exp_a;
    logic [7:0] exp_c;
    logic       exp_flag;
    logic       exp_busy;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) vis[i] = 0;
    vflag = 0;
    vbusy = 0;
  endtask

  // Drive at the falling edge, optionally check pre-edge (no same-cycle forwarding),
  // then clock and update the model; post-edge outputs are sampled 1 time unit later.
  task automatic cycle(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                       input logic fwe, input logic fin,
                       input logic [3:0] ra, input logic [3:0] rc, input bit pre_chk);
    @(negedge CLK);
    WR_EN = we; WR_ADDR = wa; WR_DATA = wd;
    FLAG_WE = fwe; FLAG_IN = fin;
    RD_A_ADDR = ra; RD_C_ADDR = rc;
    #1;
    if (pre_chk) begin
      chk("pre_rd_a", RD_A_DATA, vis[ra]);
      chk("pre_rd_c", RD_C_DATA, vis[rc]);
      chk("pre_flag", FLAG_OUT, vflag);
      chk("pre_busy", WB_BUSY, vbusy);
    end
    @(posedge CLK);
    if (we) vis[wa] = wd;
    if (fwe) vflag = fin;
    vbusy = (we || fwe) ? 1 : 0;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N = 1'b0;
    WR_EN = 0; WR_ADDR = 0; WR_DATA = 0; FLAG_WE = 0; FLAG_IN = 0;
    RD_A_ADDR = 0; RD_C_ADDR = 0;
    model_reset();

    //         we wa   wd     fwe fin ra   rc   exp_a  exp_c  fl busy
    vecs[0]  = '{1, 4'd5, 8'h03, 0, 0, 4'd5, 4'd0, 8'h03, 8'h00, 0, 1};
    vecs[1]  = '{0, 4'd0, 8'h00, 0, 0, 4'd5, 4'd0, 8'h03, 8'h00, 0, 0};
    vecs[2]  = '{1, 4'd7, 8'h11, 0, 0, 4'd5, 4'd7, 8'h03, 8'h11, 0, 1};
    vecs[3]  = '{1, 4'd7, 8'h22, 0, 0, 4'd5, 4'd7, 8'h03, 8'h22, 0, 1};
    vecs[4]  = '{0, 4'd0, 8'h00, 0, 0, 4'd5, 4'd7, 8'h03, 8'h22, 0, 0};
    vecs[5]  = '{1, 4'd1, 8'hAA, 0, 0, 4'd1, 4'd2, 8'hAA, 8'h00, 0, 1};
    vecs[6]  = '{1, 4'd2, 8'hBB, 0, 0, 4'd1, 4'd2, 8'hAA, 8'hBB, 0, 1};
    vecs[7]  = '{0, 4'd0, 8'h00, 1, 1, 4'd2, 4'd2, 8'hBB, 8'hBB, 1, 1};
    vecs[8]  = '{0, 4'd0, 8'h00, 0, 0, 4'd7, 4'd1, 8'h22, 8'hAA, 1, 0};
    vecs[9]  = '{0, 4'd0, 8'h00, 1, 0, 4'd7, 4'd1, 8'h22, 8'hAA, 0, 1};
    vecs[10] = '{0, 4'd0, 8'h00, 0, 0, 4'd7, 4'd1, 8'h22, 8'hAA, 0, 0};
    vecs[11] = '{1, 4'd9, 8'h5A, 0, 0, 4'd9, 4'd9, 8'h5A, 8'h5A, 0, 1};
    vecs[12] = '{1, 4'd15, 8'hFF, 1, 1, 4'd9, 4'd15, 8'h5A, 8'hFF, 1, 1};

    #12;
    chk("reset_rd_a", RD_A_DATA, 0);
    chk("reset_flag", FLAG_OUT, 0);
    chk("reset_busy", WB_BUSY, 0);
    @(negedge CLK);
    RESET_N = 1'b1;

    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].fwe, vecs[i].fin,
            vecs[i].ra, vecs[i].rc, 1'b0);
      chk($sformatf("vec%0d_rd_a", i), RD_A_DATA, vecs[i].exp_a);
      chk($sformatf("vec%0d_rd_c", i), RD_C_DATA, vecs[i].exp_c);
      chk($sformatf("vec%0d_flag", i), FLAG_OUT, vecs[i].exp_flag);
      chk($sformatf("vec%0d_busy", i), WB_BUSY, vecs[i].exp_busy);
    end

    // No same-cycle forwarding: R4 is still 0 before the capture edge.
    cycle(0, 4'd0, 8'h00, 0, 0, 4'd4, 4'd4, 1'b0);
    @(negedge CLK);
    WR_EN = 1; WR_ADDR = 4'd4; WR_DATA = 8'h99; RD_A_ADDR = 4'd4;
    #1;
    chk("nofwd_pre", RD_A_DATA, 8'h00);
    @(posedge CLK);
    vis[4] = 8'h99; vbusy = 1;
    #1;
    chk("nofwd_post", RD_A_DATA, 8'h99);

    // Asynchronous reset mid-cycle while R3 and the flag are still pending.
    cycle(1, 4'd3, 8'h55, 1, 1, 4'd3, 4'd4, 1'b0);
    chk("rst_pre_a", RD_A_DATA, 8'h55);
    chk("rst_pre_busy", WB_BUSY, 1);
    WR_EN = 0; FLAG_WE = 0;
    #1;
    RESET_N = 1'b0;
    #1;
    chk("rst_async_a", RD_A_DATA, 8'h00);
    chk("rst_async_c", RD_C_DATA, 8'h00);
    chk("rst_async_flag", FLAG_OUT, 0);
    chk("rst_async_busy", WB_BUSY, 0);
    model_reset();
    @(negedge CLK);
    RESET_N = 1'b1;
    cycle(0, 4'd0, 8'h00, 0, 0, 4'd3, 4'd5, 1'b0);
    chk("rst_discard_r3", RD_A_DATA, 8'h00);
    chk("rst_cleared_r5", RD_C_DATA, 8'h00);
    chk("rst_discard_flag", FLAG_OUT, 0);

    // Random traffic; narrow address range some of the time to force collisions.
    for (int n = 0; n < 400; n++) begin
      logic       we, fwe, fin;
      logic [3:0] wa, ra, rc;
      logic [7:0] wd;
      int         span;
      span = (n % 3 == 0) ? 3 : 15;
      we  = ($urandom_range(0, 3) != 0);
      fwe = ($urandom_range(0, 2) == 0);
      fin = 1'($urandom_range(0, 1));
      wa  = 4'($urandom_range(0, span));
      ra  = 4'($urandom_range(0, span));
      rc  = 4'($urandom_range(0, span));
      wd  = 8'($urandom_range(0, 255));
      cycle(we, wa, wd, fwe, fin, ra, rc, 1'b1);
      chk("rnd_rd_a", RD_A_DATA, vis[ra]);
      chk("rnd_rd_c", RD_C_DATA, vis[rc]);
      chk("rnd_flag", FLAG_OUT, vflag);
      chk("rnd_busy", WB_BUSY, vbusy);
    end

    // Sweep every register back through both ports after the stage drains.
    cycle(0, 4'd0, 8'h00, 0, 0, 4'd0, 4'd0, 1'b0);
    for (int r = 0; r < 16; r++) begin
      cycle(0, 4'd0, 8'h00, 0, 0, 4'(r), 4'(15 - r), 1'b0);
      chk("sweep_a", RD_A_DATA, vis[r]);
      chk("sweep_c", RD_C_DATA, vis[15 - r]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
